// File: rtl/warp_sched_pkg.sv
// Shared per-warp state encoding and default sizing for the warp issue controller.
package warp_sched_pkg;

  localparam int WARP_COUNT = 16;
  localparam int LAT_WIDTH  = 4;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RDY  = 3'd1,
    SEL  = 3'd2,
    WAIT = 3'd3,
    BAR  = 3'd4
  } warp_state_e;

endpackage

// File: rtl/warp_rr_pick.sv
// Combinational round-robin picker: first set request at or after start_id, wrapping at W.
module warp_rr_pick #(
  parameter int W       = 16,
  parameter int ID_BITS = $clog2(W)
) (
  input  logic [W-1:0]       req_vec,
  input  logic [ID_BITS-1:0] start_id,
  output logic [ID_BITS-1:0] pick_id,
  output logic               pick_valid
);

  function automatic logic [ID_BITS-1:0] wrap_idx(input logic [ID_BITS-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= W) s = s - W;
    return ID_BITS'(s);
  endfunction

  // Scan from the farthest offset down so the nearest request wins last.
  always_comb begin
    pick_valid = 1'b0;
    pick_id    = '0;
    for (int k = W - 1; k >= 0; k--) begin
      if (req_vec[wrap_idx(start_id, k)]) begin
        pick_valid = 1'b1;
        pick_id    = wrap_idx(start_id, k);
      end
    end
  end

endmodule

// File: rtl/warp_issue_ctrl.sv
// Per-warp lifecycle tracker with greedy-then-round-robin selection into a registered issue slot,
// plus CTA-wide barrier release and warp exit.
module warp_issue_ctrl
  import warp_sched_pkg::*;
#(
  parameter int W        = WARP_COUNT,
  parameter int LAT_BITS = LAT_WIDTH,
  parameter int ID_BITS  = $clog2(W)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [W-1:0]        warp_launch,
  output logic                issue_valid,
  output logic [ID_BITS-1:0]  issue_id,
  input  logic                issue_ready,
  input  logic [LAT_BITS-1:0] issue_lat,
  input  logic                issue_bar,
  input  logic                issue_exit,
  output logic                barrier_release,
  output logic [W-1:0]        active_vec,
  output logic                all_idle
);

  warp_state_e         state_reg  [W];
  warp_state_e         state_next [W];
  logic [LAT_BITS-1:0] cnt_reg    [W];
  logic [LAT_BITS-1:0] cnt_next   [W];

  logic                issue_valid_reg, issue_valid_next;
  logic [ID_BITS-1:0]  issue_id_reg, issue_id_next;
  logic [ID_BITS-1:0]  last_id_reg, last_id_next;
  logic                release_reg, release_next;
  logic [W-1:0]        active_reg, active_next;
  logic                all_idle_reg, all_idle_next;

  logic [W-1:0]        rdy_vec, bar_vec, busy_vec;
  logic [ID_BITS-1:0]  start_id, pick_id, win_id;
  logic                pick_valid, greedy_hit, win_valid;
  logic                accept, slot_free, bar_done;

  generate
    for (genvar gi = 0; gi < W; gi++) begin : g_vec
      assign rdy_vec[gi]  = (state_reg[gi] == RDY);
      assign bar_vec[gi]  = (state_reg[gi] == BAR);
      assign busy_vec[gi] = (state_reg[gi] != IDLE);
    end
  endgenerate

  assign accept    = issue_valid_reg && issue_ready;
  assign slot_free = !issue_valid_reg || accept;
  assign start_id  = (last_id_reg == ID_BITS'(W - 1)) ? '0 : last_id_reg + 1'b1;

  warp_rr_pick #(
    .W       (W),
    .ID_BITS (ID_BITS)
  ) u_pick (
    .req_vec    (rdy_vec),
    .start_id   (start_id),
    .pick_id    (pick_id),
    .pick_valid (pick_valid)
  );

  // The warp that just issued keeps priority whenever it is ready again.
  assign greedy_hit = rdy_vec[last_id_reg];
  assign win_id     = greedy_hit ? last_id_reg : pick_id;
  assign win_valid  = slot_free && (greedy_hit || pick_valid);

  // Barrier completes once every live warp (any non-IDLE state) is parked at it.
  assign bar_done = (|bar_vec) && (bar_vec == busy_vec);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < W; i++) begin
        state_reg[i] <= IDLE;
        cnt_reg[i]   <= '0;
      end
    end else begin
      for (int i = 0; i < W; i++) begin
        state_reg[i] <= state_next[i];
        cnt_reg[i]   <= cnt_next[i];
      end
    end
  end

  always_comb begin
    for (int i = 0; i < W; i++) begin
      state_next[i] = state_reg[i];
      cnt_next[i]   = cnt_reg[i];
      case (state_reg[i])
        IDLE: if (warp_launch[i]) state_next[i] = RDY;
        RDY:  if (win_valid && (win_id == ID_BITS'(i))) state_next[i] = SEL;
        SEL: begin
          if (accept && (issue_id_reg == ID_BITS'(i))) begin
            if (issue_exit) begin
              state_next[i] = IDLE;
            end else if (issue_bar) begin
              state_next[i] = BAR;
            end else if (issue_lat == '0) begin
              state_next[i] = RDY;
            end else begin
              state_next[i] = WAIT;
              cnt_next[i]   = issue_lat;
            end
          end
        end
        WAIT: begin
          if (cnt_reg[i] == LAT_BITS'(1)) begin
            state_next[i] = RDY;
            cnt_next[i]   = '0;
          end else begin
            cnt_next[i] = cnt_reg[i] - 1'b1;
          end
        end
        BAR:  if (bar_done) state_next[i] = RDY;
        default: state_next[i] = IDLE;
      endcase
    end
  end

  always_comb begin
    issue_valid_next = issue_valid_reg;
    issue_id_next    = issue_id_reg;
    last_id_next     = last_id_reg;
    if (slot_free) begin
      issue_valid_next = win_valid;
    end
    if (win_valid) begin
      issue_id_next = win_id;
      last_id_next  = win_id;
    end
    release_next = bar_done;
    for (int i = 0; i < W; i++) begin
      active_next[i] = (state_next[i] != IDLE);
    end
    all_idle_next = !issue_valid_next && (active_next == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      issue_valid_reg <= 1'b0;
      issue_id_reg    <= '0;
      last_id_reg     <= '0;
      release_reg     <= 1'b0;
      active_reg      <= '0;
      all_idle_reg    <= 1'b1;
    end else begin
      issue_valid_reg <= issue_valid_next;
      issue_id_reg    <= issue_id_next;
      last_id_reg     <= last_id_next;
      release_reg     <= release_next;
      active_reg      <= active_next;
      all_idle_reg    <= all_idle_next;
    end
  end

  assign issue_valid     = issue_valid_reg;
  assign issue_id        = issue_id_reg;
  assign barrier_release = release_reg;
  assign active_vec      = active_reg;
  assign all_idle        = all_idle_reg;

endmodule
